// File: rtl/hex_display_scanner_pkg.sv
// Shared types and constants for the two-digit hex display scanner.
package hex_display_pkg;

  // Scan sequence: dead-time before each digit suppresses ghosting.
  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    DIG0   = 2'd1,
    BLANK1 = 2'd2,
    DIG1   = 2'd3
  } scan_state_t;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic [1:0] ANODES_OFF = 2'b11;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}; entry 0 is the rightmost.
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_display_scanner_if.sv
// Display-side bundle: nibble inputs, scan control and the multiplexed outputs.
// No valid/ready handshake here: the nibbles are level inputs sampled only at
// the frame latch edge, and frameTick is a one-cycle strobe the cycle after it.
interface hex_display_scanner_if;
  import hex_display_pkg::*;

  logic        enable;
  logic [3:0]  topNibble;
  logic [3:0]  botNibble;
  logic [6:0]  segments;
  logic [1:0]  anodes;
  logic        frameTick;

  // Observability of the scan FSM and the latched digit pair.
  scan_state_t dbg_state;
  logic [3:0]  dbg_top;
  logic [3:0]  dbg_bot;

  modport master (
    output enable, topNibble, botNibble,
    input  segments, anodes, frameTick, dbg_state, dbg_top, dbg_bot
  );

  modport slave (
    input  enable, topNibble, botNibble,
    output segments, anodes, frameTick, dbg_state, dbg_top, dbg_bot
  );
endinterface

// File: rtl/hex_display_scanner_seg.sv
// Combinational hex-to-seven-segment glyph lookup (active-low segments).
module hex_to_seven_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Straight table lookup; every 4-bit code has a glyph.
  always_comb begin
    seg = GLYPHS[value];
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Two-digit multiplexed common-anode hex display driver with dead-time and
// per-frame latching of the displayed nibbles.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int DIGIT_CYCLES       = 50000,
  parameter int BLANK_CYCLES       = 500,
  parameter int BLANK_LEADING_ZERO = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_display_scanner_if.slave  bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
  localparam bit            LZ_BLANK = (BLANK_LEADING_ZERO != 0);

  scan_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n, dwell_last;
  logic          latch;
  logic [3:0]    top_q, bot_q, top_nx, bot_nx, glyph_in;
  logic [6:0]    glyph, seg_n;
  logic [1:0]    an_n;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          tick_q;

  // Next-state and dwell counting; disable parks the scan in BLANK0.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt + CW'(1);
    latch      = 1'b0;
    dwell_last = (state == DIG0 || state == DIG1) ? DIG_LAST : BLK_LAST;
    if (!bus.enable) begin
      state_n = BLANK0;
      cnt_n   = '0;
    end else if (cnt == dwell_last) begin
      cnt_n = '0;
      latch = (state == BLANK0);
      case (state)
        BLANK0:  state_n = DIG0;
        DIG0:    state_n = BLANK1;
        BLANK1:  state_n = DIG1;
        default: state_n = BLANK0;
      endcase
    end
  end

  // Values the latch registers will hold after this edge, so the first DIG0
  // cycle already shows the freshly captured nibble.
  always_comb begin
    top_nx   = latch ? bus.topNibble : top_q;
    bot_nx   = latch ? bus.botNibble : bot_q;
    glyph_in = (state_n == DIG1) ? top_nx : bot_nx;
  end

  hex_to_seven_seg u_seg (
    .value (glyph_in),
    .seg   (glyph)
  );

  // Output decode from the next state so pins move with the state register.
  always_comb begin
    seg_n = SEG_OFF;
    an_n  = ANODES_OFF;
    case (state_n)
      DIG0: begin
        an_n  = 2'b10;
        seg_n = glyph;
      end
      DIG1: begin
        if (!(LZ_BLANK && top_nx == 4'd0)) begin
          an_n  = 2'b01;
          seg_n = glyph;
        end
      end
      default: ;
    endcase
  end

  // State, counter, latched nibbles and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BLANK0;
      cnt    <= '0;
      top_q  <= 4'd0;
      bot_q  <= 4'd0;
      seg_q  <= SEG_OFF;
      an_q   <= ANODES_OFF;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      top_q  <= top_nx;
      bot_q  <= bot_nx;
      seg_q  <= seg_n;
      an_q   <= an_n;
      tick_q <= latch;
    end
  end

  assign bus.segments  = seg_q;
  assign bus.anodes    = an_q;
  assign bus.frameTick = tick_q;
  assign bus.dbg_state = state;
  assign bus.dbg_top   = top_q;
  assign bus.dbg_bot   = bot_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: DIGIT_CYCLES=4, BLANK_CYCLES=2,
// one instance without and one with leading-zero blanking.
module tb_hex_display_scanner;
  import hex_display_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  hex_display_scanner_if ifa ();
  hex_display_scanner_if ifb ();

  hex_display_scanner #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .BLANK_LEADING_ZERO(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  hex_display_scanner #(.DIGIT_CYCLES(4), .BLANK_CYCLES(2), .BLANK_LEADING_ZERO(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  // Clock
  always #5 clk = ~clk;

  // Hand-written glyph table, index = hex value
  logic [6:0] glyph_exp [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pins(input string tag, input int sel, input logic [1:0] an,
                          input logic [6:0] seg, input logic ft);
    if (sel == 0) begin
      chk({tag, ".an"},  {30'd0, ifa.anodes},   {30'd0, an});
      chk({tag, ".seg"}, {25'd0, ifa.segments}, {25'd0, seg});
      chk({tag, ".ft"},  {31'd0, ifa.frameTick}, {31'd0, ft});
    end else begin
      chk({tag, ".an"},  {30'd0, ifb.anodes},   {30'd0, an});
      chk({tag, ".seg"}, {25'd0, ifb.segments}, {25'd0, seg});
      chk({tag, ".ft"},  {31'd0, ifb.frameTick}, {31'd0, ft});
    end
  endtask

  // Four DIG0 cycles, frameTick on the first
  task automatic dig0(input string tag, input int sel, input logic [6:0] g);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_pins({tag, "_dig0"}, sel, 2'b10, g, (i == 0));
    end
  endtask

  // BLANK1 x2, DIG1 x4, BLANK0 x2
  task automatic tail(input string tag, input int sel, input logic [1:0] an1, input logic [6:0] g1);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_pins({tag, "_blank1"}, sel, 2'b11, 7'h7F, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_pins({tag, "_dig1"}, sel, an1, g1, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_pins({tag, "_blank0"}, sel, 2'b11, 7'h7F, 1'b0);
    end
  endtask

  // Both anodes must never be on together
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("anodes_not_00_a", {31'd0, (ifa.anodes === 2'b00)}, 32'd0);
      chk("anodes_not_00_b", {31'd0, (ifb.anodes === 2'b00)}, 32'd0);
    end
  end

  initial begin
    reset         = 1'b1;
    ifa.enable    = 1'b1;
    ifa.topNibble = 4'hA;
    ifa.botNibble = 4'h5;
    ifb.enable    = 1'b1;
    ifb.topNibble = 4'h0;
    ifb.botNibble = 4'h8;
    tick();
    tick();

    // Reset state
    chk_pins("reset", 0, 2'b11, 7'h7F, 1'b0);
    chk("reset.state", dbg_a_state(), BLANK0);
    chk("reset.top", {28'd0, ifa.dbg_top}, 32'd0);
    chk("reset.bot", {28'd0, ifa.dbg_bot}, 32'd0);

    // Test 1: basic frame, first latch two cycles after release
    reset = 1'b0;
    tick();
    chk_pins("t1_first_blank0", 0, 2'b11, 7'h7F, 1'b0);
    dig0("t1_f1", 0, 7'h12);
    tail("t1_f1", 0, 2'b01, 7'h08);
    dig0("t1_f2", 0, 7'h12);
    tail("t1_f2", 0, 2'b01, 7'h08);

    // Test 2: bot change mid-DIG0 waits for the next frame
    tick();
    chk_pins("t2_dig0_first", 0, 2'b10, 7'h12, 1'b1);
    ifa.botNibble = 4'h3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pins("t2_dig0_hold", 0, 2'b10, 7'h12, 1'b0);
    end
    tail("t2_fN", 0, 2'b01, 7'h08);
    dig0("t2_fN1", 0, 7'h30);
    chk("t2_latched_bot", {28'd0, ifa.dbg_bot}, 32'h3);

    // Test 4: disable mid-DIG1
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_pins("t4_blank1", 0, 2'b11, 7'h7F, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_pins("t4_dig1", 0, 2'b01, 7'h08, 1'b0);
    end
    ifa.enable    = 1'b0;
    ifa.botNibble = 4'h7;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pins("t4_disabled", 0, 2'b11, 7'h7F, 1'b0);
      chk("t4_disabled.state", dbg_a_state(), BLANK0);
      chk("t4_disabled.bot", {28'd0, ifa.dbg_bot}, 32'h3);
    end
    ifa.enable = 1'b1;
    tick();
    chk_pins("t4_reenable_blank0", 0, 2'b11, 7'h7F, 1'b0);
    chk("t4_reenable.bot", {28'd0, ifa.dbg_bot}, 32'h3);
    tick();
    chk_pins("t4_relatch", 0, 2'b10, 7'h78, 1'b1);
    chk("t4_relatch.bot", {28'd0, ifa.dbg_bot}, 32'h7);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_pins("t4_dig0", 0, 2'b10, 7'h78, 1'b0);
    end
    ifa.topNibble = 4'hF;
    ifa.botNibble = 4'hE;
    tail("t4_tail", 0, 2'b01, 7'h08);

    // Test 5: reset mid-DIG0 with F/E latched
    tick();
    chk_pins("t5_dig0", 0, 2'b10, 7'h06, 1'b1);
    chk("t5_latched_top", {28'd0, ifa.dbg_top}, 32'hF);
    tick();
    chk_pins("t5_dig0b", 0, 2'b10, 7'h06, 1'b0);
    reset = 1'b1;
    tick();
    chk_pins("t5_after_reset", 0, 2'b11, 7'h7F, 1'b0);
    chk("t5.state", dbg_a_state(), BLANK0);
    chk("t5.top", {28'd0, ifa.dbg_top}, 32'd0);
    chk("t5.bot", {28'd0, ifa.dbg_bot}, 32'd0);
    reset = 1'b0;

    // Test 6: sweep all glyphs through bot (top stays F)
    ifa.botNibble = 4'h0;
    tick();
    chk_pins("t6_blank0", 0, 2'b11, 7'h7F, 1'b0);
    for (int v = 0; v < 16; v++) begin
      ifa.botNibble = 4'(v);
      dig0($sformatf("t6_v%0h", v), 0, glyph_exp[v]);
      tail($sformatf("t6_v%0h", v), 0, 2'b01, 7'h0E);
    end

    // Test 3: leading-zero blanking on the second instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk_pins("t3_blank0", 1, 2'b11, 7'h7F, 1'b0);
    dig0("t3_top0", 1, 7'h00);
    ifb.topNibble = 4'h1;
    tail("t3_top0", 1, 2'b11, 7'h7F);
    dig0("t3_top1", 1, 7'h00);
    tail("t3_top1", 1, 2'b01, 7'h79);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [31:0] dbg_a_state();
    return {30'd0, ifa.dbg_state};
  endfunction

endmodule
